control_unit: RTL and testbench

//  Multi-cycle control sequencer for the bus datapath: sole driver of every datapath control input.

---
 rtl/control_unit.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle control sequencer: sole driver of every datapath control strobe.
// Optional feature macro ILLEGAL_TRAP_EN: undefined opcodes raise Illegal and halt.
module control_unit #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        PCout,
    output logic        IncPC,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        wren,
    output logic        IRin,
    output logic        IRout,
    output logic        Yin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Cout,
    output logic        InPortout,
    output logic        outPortEnable,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        conInput,
    output logic [3:0]  ctrl,
    output logic        Run,
    output logic        Illegal
);

    localparam logic [1:0] MW = 2'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_CLR, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MD, C_UN, C_BR,
        C_JR, C_IN, C_OUT, C_MFLO, C_MFHI, C_NOP, C_HALT, C_BAD
    } cls_e;

    typedef struct packed {
        logic       pc_out;
        logic       inc_pc;
        logic       pc_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       read;
        logic       wren;
        logic       ir_in;
        logic       ir_out;
        logic       y_in;
        logic       zhi_in;
        logic       zlo_in;
        logic       zhi_out;
        logic       zlo_out;
        logic       hi_in;
        logic       hi_out;
        logic       lo_in;
        logic       lo_out;
        logic       c_out;
        logic       inp_out;
        logic       outp_en;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       con_in;
        logic [3:0] ctrl;
    } cw_t;

    state_e     state_q, state_d;
    logic [1:0] wait_q, wait_d;
    cw_t        cw_q, cw_d;
    logic       run_q;
    cls_e       cls;
    logic [3:0] alu;
    state_e     last;
    logic       mem_hold;
    logic       trap;
    logic [4:0] opc;
    logic       unused_ir;

    assign opc       = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_comb begin
        cls = C_BAD;
        case (opc)
            5'h00: cls = C_LD;
            5'h01: cls = C_LDI;
            5'h02: cls = C_ST;
            5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
            5'h08, 5'h09, 5'h0A, 5'h0B: cls = C_ALU;
            5'h0C, 5'h0D, 5'h0E: cls = C_IMM;
            5'h0F, 5'h10: cls = C_MD;
            5'h11, 5'h12: cls = C_UN;
            5'h13: cls = C_BR;
            5'h14: cls = C_JR;
            5'h16: cls = C_IN;
            5'h17: cls = C_OUT;
            5'h18: cls = C_MFLO;
            5'h19: cls = C_MFHI;
            5'h1A: cls = C_NOP;
            5'h1B: cls = C_HALT;
            default: cls = C_BAD;
        endcase
    end

    always_comb begin
        alu = 4'h0;
        case (opc)
            5'h04: alu = 4'h1;
            5'h05: alu = 4'h2;
            5'h06: alu = 4'h3;
            5'h07: alu = 4'h4;
            5'h08: alu = 4'h5;
            5'h09: alu = 4'h6;
            5'h0A: alu = 4'h7;
            5'h0B: alu = 4'h8;
            5'h0D: alu = 4'h2;
            5'h0E: alu = 4'h3;
            5'h0F: alu = 4'h9;
            5'h10: alu = 4'hA;
            5'h11: alu = 4'hB;
            5'h12: alu = 4'hC;
            default: alu = 4'h0;
        endcase
    end

    always_comb begin
        last = S_T3;
        case (cls)
            C_ALU, C_IMM, C_LDI: last = S_T5;
            C_LD, C_ST:          last = S_T7;
            C_MD, C_BR:          last = S_T6;
            C_UN:                last = S_T4;
            default:             last = S_T3;
        endcase
    end

    assign mem_hold = (cls == C_LD && state_q == S_T6) ||
                      (cls == C_ST && state_q == S_T7);

`ifdef ILLEGAL_TRAP_EN
    assign trap = (cls == C_BAD);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = 2'd0;
        unique case (state_q)
            S_CLR:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                if (wait_q < MW) begin
                    wait_d = wait_q + 2'd1;
                end else begin
                    state_d = S_T2;
                end
            end
            S_T2:   state_d = trap ? S_HALT : S_T3;
            S_HALT: state_d = S_HALT;
            default: begin
                if (mem_hold && wait_q < MW) begin
                    wait_d = wait_q + 2'd1;
                end else if (state_q == last) begin
                    state_d = (Stop || cls == C_HALT) ? S_HALT : S_T0;
                end else begin
                    state_d = state_e'(state_q + 4'd1);
                end
            end
        endcase
    end

    // Word is built for the state being entered so outputs align with state_q.
    always_comb begin
        cw_d = '0;
        unique case (state_d)
            S_T0: begin
                cw_d.pc_out = 1'b1;
                cw_d.mar_in = 1'b1;
                cw_d.inc_pc = 1'b1;
                cw_d.zlo_in = 1'b1;
            end
            S_T1: begin
                cw_d.read   = 1'b1;
                cw_d.mdr_in = 1'b1;
                if (state_q != S_T1) begin
                    cw_d.zlo_out = 1'b1;
                    cw_d.pc_in   = 1'b1;
                end
            end
            S_T2: begin
                cw_d.mdr_out = 1'b1;
                cw_d.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU, C_IMM: begin
                        cw_d.grb   = 1'b1;
                        cw_d.r_out = 1'b1;
                        cw_d.y_in  = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        cw_d.grb    = 1'b1;
                        cw_d.ba_out = 1'b1;
                        cw_d.y_in   = 1'b1;
                    end
                    C_MD: begin
                        cw_d.gra   = 1'b1;
                        cw_d.r_out = 1'b1;
                        cw_d.y_in  = 1'b1;
                    end
                    C_UN: begin
                        cw_d.grb    = 1'b1;
                        cw_d.r_out  = 1'b1;
                        cw_d.zlo_in = 1'b1;
                        cw_d.ctrl   = alu;
                    end
                    C_BR: begin
                        cw_d.gra    = 1'b1;
                        cw_d.r_out  = 1'b1;
                        cw_d.con_in = 1'b1;
                    end
                    C_JR: begin
                        cw_d.gra   = 1'b1;
                        cw_d.r_out = 1'b1;
                        cw_d.pc_in = 1'b1;
                    end
                    C_IN: begin
                        cw_d.inp_out = 1'b1;
                        cw_d.gra     = 1'b1;
                        cw_d.r_in    = 1'b1;
                    end
                    C_OUT: begin
                        cw_d.gra     = 1'b1;
                        cw_d.r_out   = 1'b1;
                        cw_d.outp_en = 1'b1;
                    end
                    C_MFLO: begin
                        cw_d.lo_out = 1'b1;
                        cw_d.gra    = 1'b1;
                        cw_d.r_in   = 1'b1;
                    end
                    C_MFHI: begin
                        cw_d.hi_out = 1'b1;
                        cw_d.gra    = 1'b1;
                        cw_d.r_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU, C_MD: begin
                        cw_d.grc    = (cls == C_ALU);
                        cw_d.grb    = (cls == C_MD);
                        cw_d.r_out  = 1'b1;
                        cw_d.zlo_in = 1'b1;
                        cw_d.zhi_in = 1'b1;
                        cw_d.ctrl   = alu;
                    end
                    C_IMM, C_LD, C_LDI, C_ST: begin
                        cw_d.c_out  = 1'b1;
                        cw_d.zlo_in = 1'b1;
                        cw_d.ctrl   = alu;
                    end
                    C_UN: begin
                        cw_d.zlo_out = 1'b1;
                        cw_d.gra     = 1'b1;
                        cw_d.r_in    = 1'b1;
                    end
                    C_BR: begin
                        cw_d.pc_out = 1'b1;
                        cw_d.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU, C_IMM, C_LDI: begin
                        cw_d.zlo_out = 1'b1;
                        cw_d.gra     = 1'b1;
                        cw_d.r_in    = 1'b1;
                    end
                    C_LD, C_ST: begin
                        cw_d.zlo_out = 1'b1;
                        cw_d.mar_in  = 1'b1;
                    end
                    C_MD: begin
                        cw_d.zlo_out = 1'b1;
                        cw_d.lo_in   = 1'b1;
                    end
                    C_BR: begin
                        cw_d.c_out  = 1'b1;
                        cw_d.zlo_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        cw_d.read   = 1'b1;
                        cw_d.mdr_in = 1'b1;
                    end
                    C_ST: begin
                        cw_d.gra    = 1'b1;
                        cw_d.r_out  = 1'b1;
                        cw_d.mdr_in = 1'b1;
                    end
                    C_MD: begin
                        cw_d.zhi_out = 1'b1;
                        cw_d.hi_in   = 1'b1;
                    end
                    C_BR: begin
                        cw_d.zlo_out = CON;
                        cw_d.pc_in   = CON;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin
                        cw_d.mdr_out = 1'b1;
                        cw_d.gra     = 1'b1;
                        cw_d.r_in    = 1'b1;
                    end
                    C_ST: begin
                        cw_d.mdr_out = 1'b1;
                        cw_d.wren    = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_CLR;
            wait_q  <= 2'd0;
            cw_q    <= '0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cw_q    <= cw_d;
            run_q   <= (state_d != S_HALT);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic ill_q;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            ill_q <= 1'b0;
        end else if (state_q == S_T2 && trap) begin
            ill_q <= 1'b1;
        end
    end

    assign Illegal = ill_q;
`else
    assign Illegal = 1'b0;
`endif

    assign PCout         = cw_q.pc_out;
    assign IncPC         = cw_q.inc_pc;
    assign PCin          = cw_q.pc_in;
    assign MARin         = cw_q.mar_in;
    assign MDRin         = cw_q.mdr_in;
    assign MDRout        = cw_q.mdr_out;
    assign Read          = cw_q.read;
    assign wren          = cw_q.wren;
    assign IRin          = cw_q.ir_in;
    assign IRout         = cw_q.ir_out;
    assign Yin           = cw_q.y_in;
    assign Zhighin       = cw_q.zhi_in;
    assign Zlowin        = cw_q.zlo_in;
    assign Zhighout      = cw_q.zhi_out;
    assign Zlowout       = cw_q.zlo_out;
    assign HIin          = cw_q.hi_in;
    assign HIout         = cw_q.hi_out;
    assign LOin          = cw_q.lo_in;
    assign LOout         = cw_q.lo_out;
    assign Cout          = cw_q.c_out;
    assign InPortout     = cw_q.inp_out;
    assign outPortEnable = cw_q.outp_en;
    assign Gra           = cw_q.gra;
    assign Grb           = cw_q.grb;
    assign Grc           = cw_q.grc;
    assign Rin           = cw_q.r_in;
    assign Rout          = cw_q.r_out;
    assign BAout         = cw_q.ba_out;
    assign conInput      = cw_q.con_in;
    assign ctrl          = cw_q.ctrl;
    assign Run           = run_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-instruction control-word
// sequences from a step-table model, compared by a free-running monitor.
module tb_control_unit;

    localparam int MW = 1;

    localparam int PCOUT = 0, INCPC = 1, PCIN = 2, MARIN = 3;
    localparam int MDRIN = 4, MDROUT = 5, READ = 6, WREN = 7;
    localparam int IRIN = 8, YIN = 10, ZHIIN = 11;
    localparam int ZLOIN = 12, ZHIOUT = 13, ZLOOUT = 14, HIIN = 15;
    localparam int HIOUT = 16, LOIN = 17, LOOUT = 18, COUT = 19;
    localparam int INPOUT = 20, OUTPEN = 21, GRA = 22, GRB = 23;
    localparam int GRC = 24, RIN = 25, ROUT = 26, BAOUT = 27;
    localparam int CONIN = 28, CTRL = 29, RUN = 33, ILL = 34;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic [31:0] IR = '0;
    logic        CON = 1'b0;
    logic        Stop = 1'b0;
    logic PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, wren, IRin, IRout;
    logic Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, HIout, LOin, LOout;
    logic Cout, InPortout, outPortEnable, Gra, Grb, Grc, Rin, Rout, BAout;
    logic conInput, Run, Illegal;
    logic [3:0] ctrl;

    control_unit #(.MEM_WAIT(MW)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .wren(wren),
        .IRin(IRin), .IRout(IRout), .Yin(Yin), .Zhighin(Zhighin),
        .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Cout(Cout), .InPortout(InPortout), .outPortEnable(outPortEnable),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .conInput(conInput), .ctrl(ctrl), .Run(Run),
        .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    logic [34:0] obs;
    assign obs = {Illegal, Run, ctrl, conInput, BAout, Rout, Rin, Grc,
                  Grb, Gra, outPortEnable, InPortout, Cout, LOout, LOin,
                  HIout, HIin, Zlowout, Zhighout, Zlowin, Zhighin, Yin,
                  IRout, IRin, wren, Read, MDRout, MDRin, MARin, PCin,
                  IncPC, PCout};

    logic [34:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          ill_m = 1'b0;

    function automatic logic [34:0] b(input int i);
        return 35'd1 << i;
    endfunction

    function automatic logic [34:0] c(input int v);
        return 35'(v) << CTRL;
    endfunction

    always @(negedge Clock) begin
        logic [34:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL word cyc=%0d IR=%h got=%h exp=%h",
                         cyc, IR, obs, e);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge Clock);
        #1;
    endtask

    function automatic logic [34:0] t0w();
        return b(PCOUT) | b(MARIN) | b(INCPC) | b(ZLOIN) | b(RUN);
    endfunction

    function automatic logic [34:0] haltw();
        return ill_m ? b(ILL) : 35'd0;
    endfunction

    task automatic do_clear(input int n);
        Clear = 1'b1;
        ill_m = 1'b0;
        repeat (n) exp_q.push_back(b(RUN));
        wait_n(n);
        Clear = 1'b0;
        exp_q.push_back(t0w());
        wait_n(1);
    endtask

    // Steps after T0 for one instruction, then the word that follows it.
    task automatic instr(input logic [31:0] ir, input bit con,
                         input bit stop);
        logic [34:0] s[$];
        int   op;
        bit   halted;
        op     = int'(ir[31:27]);
        IR     = ir;
        CON    = con;
        Stop   = stop;
        halted = stop;
        s.push_back(b(ZLOOUT) | b(PCIN) | b(READ) | b(MDRIN));
        repeat (MW) s.push_back(b(READ) | b(MDRIN));
        s.push_back(b(MDROUT) | b(IRIN));
        if (op >= 3 && op <= 11) begin
            s.push_back(b(GRB) | b(ROUT) | b(YIN));
            s.push_back(b(GRC) | b(ROUT) | b(ZLOIN) | b(ZHIIN) | c(op - 3));
            s.push_back(b(ZLOOUT) | b(GRA) | b(RIN));
        end else if (op >= 12 && op <= 14) begin
            s.push_back(b(GRB) | b(ROUT) | b(YIN));
            s.push_back(b(COUT) | b(ZLOIN) | c(op == 12 ? 0 : op - 11));
            s.push_back(b(ZLOOUT) | b(GRA) | b(RIN));
        end else if (op <= 2) begin
            s.push_back(b(GRB) | b(BAOUT) | b(YIN));
            s.push_back(b(COUT) | b(ZLOIN));
            if (op == 1) begin
                s.push_back(b(ZLOOUT) | b(GRA) | b(RIN));
            end else if (op == 0) begin
                s.push_back(b(ZLOOUT) | b(MARIN));
                repeat (MW + 1) s.push_back(b(READ) | b(MDRIN));
                s.push_back(b(MDROUT) | b(GRA) | b(RIN));
            end else begin
                s.push_back(b(ZLOOUT) | b(MARIN));
                s.push_back(b(GRA) | b(ROUT) | b(MDRIN));
                repeat (MW + 1) s.push_back(b(MDROUT) | b(WREN));
            end
        end else if (op == 15 || op == 16) begin
            s.push_back(b(GRA) | b(ROUT) | b(YIN));
            s.push_back(b(GRB) | b(ROUT) | b(ZLOIN) | b(ZHIIN) | c(op - 6));
            s.push_back(b(ZLOOUT) | b(LOIN));
            s.push_back(b(ZHIOUT) | b(HIIN));
        end else if (op == 17 || op == 18) begin
            s.push_back(b(GRB) | b(ROUT) | b(ZLOIN) | c(op - 6));
            s.push_back(b(ZLOOUT) | b(GRA) | b(RIN));
        end else if (op == 19) begin
            s.push_back(b(GRA) | b(ROUT) | b(CONIN));
            s.push_back(b(PCOUT) | b(YIN));
            s.push_back(b(COUT) | b(ZLOIN));
            s.push_back(con ? (b(ZLOOUT) | b(PCIN)) : 35'd0);
        end else if (op == 20) begin
            s.push_back(b(GRA) | b(ROUT) | b(PCIN));
        end else if (op == 22) begin
            s.push_back(b(INPOUT) | b(GRA) | b(RIN));
        end else if (op == 23) begin
            s.push_back(b(GRA) | b(ROUT) | b(OUTPEN));
        end else if (op == 24) begin
            s.push_back(b(LOOUT) | b(GRA) | b(RIN));
        end else if (op == 25) begin
            s.push_back(b(HIOUT) | b(GRA) | b(RIN));
        end else if (op == 26) begin
            s.push_back(35'd0);
        end else if (op == 27) begin
            s.push_back(35'd0);
            halted = 1'b1;
        end else if (TRAP) begin
            halted = 1'b1;
            ill_m  = 1'b1;
        end else begin
            s.push_back(35'd0);
        end
        foreach (s[i]) exp_q.push_back(s[i] | b(RUN));
        exp_q.push_back(halted ? haltw() : t0w());
        wait_n(s.size() + 1);
        if (halted) begin
            repeat (3) exp_q.push_back(haltw());
            wait_n(3);
            Stop = 1'b0;
            do_clear(2);
        end
    endtask

    initial begin
        logic [31:0] r;
        int          op;
        @(negedge Clock);
        #1;
        do_clear(2);
        instr(32'h19198000, 1'b0, 1'b0);
        instr(32'h1091_8000, 1'b1, 1'b0);
        instr(32'h0091_0004, 1'b0, 1'b0);
        instr(32'h9880_0010, 1'b0, 1'b0);
        instr(32'h9880_0010, 1'b1, 1'b0);
        instr(32'h8119_0000, 1'b0, 1'b1);
        instr(32'hF800_0000, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++) begin
            r  = $urandom();
            op = int'($urandom_range(0, 31));
            instr({5'(op), r[26:0]}, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 11) == 0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d need=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
